// File: rtl/period_meter_if.sv
// Measurement bus for period_meter: enable and signal-under-test in,
// measurement results and status strobes out.
interface period_meter_if #(
   parameter int WIDTH = 16
);
   logic             en;
   logic             sig_in;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] high_time;
   logic             valid;
   logic             timeout;
   logic             busy;

   // Side that controls the meter and consumes results (bench, readout logic)
   modport master (
      output en,
      output sig_in,
      input  period,
      input  high_time,
      input  valid,
      input  timeout,
      input  busy
   );

   // The meter itself
   modport slave (
      input  en,
      input  sig_in,
      output period,
      output high_time,
      output valid,
      output timeout,
      output busy
   );
endinterface

// File: rtl/period_meter.sv
// period_meter: measures period and high time of an asynchronous input in
// clk cycles. Results are published with a one-cycle valid strobe; a missing
// rising edge for 2^WIDTH-1 cycles produces a one-cycle timeout strobe.
module period_meter #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   period_meter_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   state_t           state_reg;
   logic             s1_reg;
   logic             s2_reg;
   logic             s3_reg;
   logic             rise;
   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] hacc_reg;
   logic [WIDTH-1:0] period_reg;
   logic [WIDTH-1:0] high_reg;
   logic             valid_reg;
   logic             timeout_reg;
   logic             busy_reg;

   // Rising edge of the synchronised input; s3 is just a delayed copy of s2
   assign rise = s2_reg & ~s3_reg;

   // Two-flop synchroniser plus edge-detect delay flop, free-running in every state
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
         s3_reg <= 1'b0;
      end else begin
         s1_reg <= bus.sig_in;
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
      end
   end

   // Measurement FSM: counts clk edges between rises and accumulates high cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         hacc_reg    <= '0;
         period_reg  <= '0;
         high_reg    <= '0;
         valid_reg   <= 1'b0;
         timeout_reg <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-asserted below
         valid_reg   <= 1'b0;
         timeout_reg <= 1'b0;
         if (!bus.en) begin
            // Dropping enable abandons any partial measurement; results hold
            state_reg <= IDLE;
            cnt_reg   <= '0;
            hacc_reg  <= '0;
            busy_reg  <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  state_reg <= ARM;
                  busy_reg  <= 1'b1;
               end
               ARM: begin
                  // First edge only starts the count; nothing to publish yet
                  if (rise) begin
                     cnt_reg   <= {{(WIDTH-1){1'b0}}, 1'b1};
                     hacc_reg  <= {{(WIDTH-1){1'b0}}, 1'b1};
                     state_reg <= MEAS;
                  end
               end
               MEAS: begin
                  // A rise takes precedence over the timeout limit
                  if (rise) begin
                     period_reg <= cnt_reg;
                     high_reg   <= hacc_reg;
                     valid_reg  <= 1'b1;
                     cnt_reg    <= {{(WIDTH-1){1'b0}}, 1'b1};
                     hacc_reg   <= {{(WIDTH-1){1'b0}}, 1'b1};
                  end else if (cnt_reg == CNT_MAX) begin
                     timeout_reg <= 1'b1;
                     cnt_reg     <= '0;
                     hacc_reg    <= '0;
                     state_reg   <= ARM;
                  end else begin
                     // hacc never exceeds cnt, so it cannot wrap first
                     cnt_reg  <= cnt_reg + 1'b1;
                     hacc_reg <= hacc_reg + WIDTH'(s2_reg);
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.period    = period_reg;
   assign bus.high_time = high_reg;
   assign bus.valid     = valid_reg;
   assign bus.timeout   = timeout_reg;
   assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: a 16-bit instance for normal/abort behaviour and an
// 8-bit instance for timeout and boundary behaviour. Expected events are
// queued from the stimulus parameters and matched by a monitor on each strobe.
module tb_period_meter;

   typedef struct {
      int kind;    // 0 = valid, 1 = timeout
      int period;
      int high;
      int cyc;     // cycle count at which the strobe must be visible
   } exp_t;

   logic clk = 1'b0;
   logic sig = 1'b0;
   logic en_sig [2];
   logic rst_sig [2];
   int   cyc = 0;

   int   n_assert = 0;
   int   n_fail   = 0;

   exp_t q16 [$];
   exp_t q8  [$];

   int   armed [2];
   int   last_hi [2];
   int   last_lo [2];
   int   last_per [2];
   int   last_high [2];

   period_meter_if #(.WIDTH(16)) bus16 ();
   period_meter_if #(.WIDTH(8))  bus8 ();

   assign bus16.en     = en_sig[0];
   assign bus16.sig_in = sig;
   assign bus8.en      = en_sig[1];
   assign bus8.sig_in  = sig;

   period_meter #(.WIDTH(16)) dut16 (
      .clk (clk),
      .rst (rst_sig[0]),
      .bus (bus16)
   );

   period_meter #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst_sig[1]),
      .bus (bus8)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Match one observed strobe against the head of that instance's queue
   task automatic check_event(input int d, input logic v, input logic t,
                              input int p, input int h);
      exp_t  e;
      int    qs;
      string pre;
      pre = (d != 0) ? "d8_" : "d16_";
      qs  = (d != 0) ? q8.size() : q16.size();
      $display("event %scyc=%0d valid=%0d timeout=%0d period=%0d high=%0d",
               pre, cyc, v, t, p, h);
      chk({pre, "event_expected"}, (qs > 0) ? 1 : 0, 1);
      if (qs > 0) begin
         e = (d != 0) ? q8.pop_front() : q16.pop_front();
         chk({pre, "valid_and_timeout"}, int'(v & t), 0);
         chk({pre, "kind"}, t ? 1 : 0, e.kind);
         chk({pre, "cycle"}, cyc, e.cyc);
         chk({pre, "period"}, p, e.period);
         chk({pre, "high_time"}, h, e.high);
      end
   endtask

   // Monitor: every strobe must correspond to a queued expectation
   always @(negedge clk) begin
      if (bus16.valid || bus16.timeout)
         check_event(0, bus16.valid, bus16.timeout, int'(bus16.period), int'(bus16.high_time));
      if (bus8.valid || bus8.timeout)
         check_event(1, bus8.valid, bus8.timeout, int'(bus8.period), int'(bus8.high_time));
   end

   task automatic push(input int d, input exp_t e);
      if (d != 0) q8.push_back(e);
      else        q16.push_back(e);
   endtask

   // One input cycle: high for hi clk, low for lo clk, starting at a negedge.
   // Optionally drops en (or pulses rst) for one cycle at offset abort_at.
   task automatic pulse(input int d, input int hi, input int lo,
                        input int abort_at, input bit by_rst);
      exp_t e;
      int   lim;
      lim = (d != 0) ? 255 : 65535;
      if (armed[d] != 0) begin
         e.kind   = 0;
         e.period = last_hi[d] + last_lo[d];
         e.high   = last_hi[d];
         e.cyc    = cyc + 3;
         push(d, e);
         last_per[d]  = e.period;
         last_high[d] = e.high;
      end
      if (hi + lo > lim) begin
         e.kind   = 1;
         e.period = last_per[d];
         e.high   = last_high[d];
         e.cyc    = cyc + 3 + lim;
         push(d, e);
         armed[d] = 0;
      end else begin
         armed[d] = 1;
      end
      last_hi[d] = hi;
      last_lo[d] = lo;
      for (int i = 0; i < hi + lo; i++) begin
         sig = (i < hi);
         if (i == abort_at) begin
            if (by_rst) rst_sig[d] = 1'b1;
            else        en_sig[d]  = 1'b0;
         end
         if (i == abort_at + 1) begin
            rst_sig[d] = 1'b0;
            en_sig[d]  = 1'b1;
         end
         @(negedge clk);
      end
      if (abort_at >= 0) begin
         armed[d] = 0;
         if (by_rst) begin
            last_per[d]  = 0;
            last_high[d] = 0;
         end
      end
   endtask

   task automatic stop_phase(input int d);
      en_sig[d] = 1'b0;
      armed[d]  = 0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: observed time limit reached, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         armed[d] = 0; last_hi[d] = 0; last_lo[d] = 0;
         last_per[d] = 0; last_high[d] = 0;
         en_sig[d] = 1'b0; rst_sig[d] = 1'b1;
      end

      // Reset / idle: rst for 3 cycles, then en=0 with sig toggling
      for (int i = 0; i < 100; i++) begin
         if (i == 3) begin
            rst_sig[0] = 1'b0;
            rst_sig[1] = 1'b0;
         end
         sig = (i % 6) < 3;
         @(negedge clk);
      end
      sig = 1'b0;
      chk("reset_period",  int'(bus16.period), 0);
      chk("reset_high",    int'(bus16.high_time), 0);
      chk("reset_valid",   int'(bus16.valid), 0);
      chk("reset_timeout", int'(bus16.timeout), 0);
      chk("reset_busy",    int'(bus16.busy), 0);
      chk("reset8_busy",   int'(bus8.busy), 0);

      // 16-bit instance: square, asymmetric and slow inputs
      en_sig[0] = 1'b1;
      repeat (2) @(negedge clk);
      chk("busy_armed", int'(bus16.busy), 1);
      repeat (6) pulse(0, 5, 5, -1, 1'b0);
      chk("square_period", int'(bus16.period), 10);
      chk("square_high",   int'(bus16.high_time), 5);
      repeat (4) pulse(0, 3, 17, -1, 1'b0);
      repeat (3) pulse(0, 250, 750, -1, 1'b0);
      chk("slow_period", int'(bus16.period), 1000);
      chk("slow_high",   int'(bus16.high_time), 250);

      // Enable abort halfway through a period: results hold
      repeat (3) pulse(0, 5, 5, -1, 1'b0);
      pulse(0, 5, 5, 5, 1'b0);
      chk("en_abort_period", int'(bus16.period), 10);
      chk("en_abort_high",   int'(bus16.high_time), 5);
      repeat (3) pulse(0, 4, 8, -1, 1'b0);

      // Reset abort halfway through a period: results cleared
      pulse(0, 6, 6, 6, 1'b1);
      chk("rst_abort_period", int'(bus16.period), 0);
      chk("rst_abort_high",   int'(bus16.high_time), 0);
      repeat (3) pulse(0, 4, 4, -1, 1'b0);
      repeat (3) pulse(0, 2, 2, -1, 1'b0);
      chk("min_period", int'(bus16.period), 4);
      stop_phase(0);
      chk("idle_busy", int'(bus16.busy), 0);
      chk("idle_hold_period", int'(bus16.period), 4);

      // 8-bit instance: timeout, re-arm, constant high, exact-limit boundary
      en_sig[1] = 1'b1;
      repeat (2) @(negedge clk);
      repeat (2) pulse(1, 10, 30, -1, 1'b0);
      pulse(1, 3, 300, -1, 1'b0);
      chk("timeout_keeps_period", int'(bus8.period), 40);
      repeat (2) pulse(1, 10, 50, -1, 1'b0);
      pulse(1, 300, 1, -1, 1'b0);
      chk("const_high_period", int'(bus8.period), 60);
      repeat (3) pulse(1, 10, 245, -1, 1'b0);
      chk("boundary_period", int'(bus8.period), 255);
      chk("boundary_high",   int'(bus8.high_time), 10);
      stop_phase(1);

      repeat (5) @(negedge clk);
      chk("q16_drained", q16.size(), 0);
      chk("q8_drained",  q8.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
